// File: rtl/bitstream_fifo_conv.sv
// Width-converting FIFO built on a circular bit buffer. It accepts WIN-bit writes and
// presents WOUT-bit reads, both LSB-first. The head chunk is shown first-word-fall-through.
// The fill level is exact, and the overflow/underflow flags stay set until cleared.
module bitstream_fifo_conv #(
   parameter int unsigned WIN  = 8,
   parameter int unsigned WOUT = 3,
   parameter int unsigned CAP  = 128,
   parameter int unsigned LW   = $clog2(CAP + 1)
) (
   input  logic            clk,
   input  logic            rst,
   input  logic            w_en,
   input  logic [WIN-1:0]  data_w,
   input  logic            r_en,
   input  logic            err_clr,
   output logic [WOUT-1:0] data_r,
   output logic            empty,
   output logic            full,
   output logic            half_full,
   output logic            overflow,
   output logic            underflow,
   output logic [LW-1:0]   level
);

   localparam int unsigned PW = (CAP > 1) ? $clog2(CAP) : 1;

   localparam logic [LW-1:0] WinL  = LW'(WIN);
   localparam logic [LW-1:0] WoutL = LW'(WOUT);
   localparam logic [LW-1:0] CapL  = LW'(CAP);
   localparam logic [LW-1:0] HalfL = LW'(CAP / 2);

   logic [CAP-1:0] mem_q;
   logic [PW-1:0]  wp_q, wp_d, rp_q, rp_d;
   logic [LW-1:0]  level_q, level_d;
   logic           overflow_q, overflow_d, underflow_q, underflow_d;
   logic           wr, rd;

   // (base + off) mod CAP. base < CAP and off < CAP, so at most one subtraction is needed.
   function automatic logic [PW-1:0] wrap_add(input logic [PW-1:0] base, input int unsigned off);
      logic [PW:0] s;
      s = {1'b0, base} + (PW + 1)'(off);
      if (s >= (PW + 1)'(CAP)) s = s - (PW + 1)'(CAP);
      return s[PW-1:0];
   endfunction

   // Status flags come straight from the registered level
   always_comb begin
      empty     = level_q < WoutL;
      full      = (CapL - level_q) < WinL;
      half_full = (level_q >= HalfL) && !full;
      wr        = w_en && !full;
      rd        = r_en && !empty;
   end

   // Head chunk: bits beyond the fill level read as zero, so stale storage is never visible
   always_comb begin
      data_r = '0;
      for (int unsigned i = 0; i < WOUT; i++) begin
         if (LW'(i) < level_q) data_r[i] = mem_q[wrap_add(rp_q, i)];
      end
   end

   // Next-state for pointers, level and the sticky error flags (set beats clear)
   always_comb begin
      wp_d        = wr ? wrap_add(wp_q, WIN) : wp_q;
      rp_d        = rd ? wrap_add(rp_q, WOUT) : rp_q;
      level_d     = level_q + (wr ? WinL : '0) - (rd ? WoutL : '0);
      overflow_d  = overflow_q;
      underflow_d = underflow_q;
      if (err_clr) begin
         overflow_d  = 1'b0;
         underflow_d = 1'b0;
      end
      if (w_en && full)  overflow_d  = 1'b1;
      if (r_en && empty) underflow_d = 1'b1;
   end

   // Control state register
   always_ff @(posedge clk) begin
      if (rst) begin
         wp_q        <= '0;
         rp_q        <= '0;
         level_q     <= '0;
         overflow_q  <= 1'b0;
         underflow_q <= 1'b0;
      end else begin
         wp_q        <= wp_d;
         rp_q        <= rp_d;
         level_q     <= level_d;
         overflow_q  <= overflow_d;
         underflow_q <= underflow_d;
      end
   end

   // Bit storage is never reset; the level mask on data_r hides its contents
   always_ff @(posedge clk) begin
      if (wr && !rst) begin
         for (int unsigned i = 0; i < WIN; i++) mem_q[wrap_add(wp_q, i)] <= data_w[i];
      end
   end

   assign overflow  = overflow_q;
   assign underflow = underflow_q;
   assign level     = level_q;

endmodule

// File: tb/tb_bitstream_fifo_conv.sv
// Directed bench for bitstream_fifo_conv at WIN=8, WOUT=3, CAP=128.
module tb_bitstream_fifo_conv;

   logic       clk = 1'b0;
   logic       rst = 1'b0;
   logic       w_en = 1'b0;
   logic [7:0] data_w = '0;
   logic       r_en = 1'b0;
   logic       err_clr = 1'b0;
   logic [2:0] data_r;
   logic       empty, full, half_full, overflow, underflow;
   logic [7:0] level;

   int n_checks = 0;
   int n_fail   = 0;

   bitstream_fifo_conv #(.WIN(8), .WOUT(3), .CAP(128)) dut (
      .clk       (clk),
      .rst       (rst),
      .w_en      (w_en),
      .data_w    (data_w),
      .r_en      (r_en),
      .err_clr   (err_clr),
      .data_r    (data_r),
      .empty     (empty),
      .full      (full),
      .half_full (half_full),
      .overflow  (overflow),
      .underflow (underflow),
      .level     (level)
   );

   always #5 clk = ~clk;

   // Inputs change and outputs are sampled 1 time unit after each rising edge
   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic write_byte(input logic [7:0] d);
      w_en = 1'b1; data_w = d;
      tick();
      w_en = 1'b0;
   endtask

   task automatic test_reset();
      rst = 1'b1; tick(); tick(); rst = 1'b0;
      n_checks++; if (empty !== 1'b1) begin n_fail++; $display("FAIL reset_empty got %b want 1", empty); end
      n_checks++; if (full !== 1'b0) begin n_fail++; $display("FAIL reset_full got %b want 0", full); end
      n_checks++; if (half_full !== 1'b0) begin n_fail++; $display("FAIL reset_half got %b want 0", half_full); end
      n_checks++; if (overflow !== 1'b0) begin n_fail++; $display("FAIL reset_ovf got %b want 0", overflow); end
      n_checks++; if (underflow !== 1'b0) begin n_fail++; $display("FAIL reset_unf got %b want 0", underflow); end
      n_checks++; if (level !== 8'd0) begin n_fail++; $display("FAIL reset_level got %0d want 0", level); end
      n_checks++; if (data_r !== 3'd0) begin n_fail++; $display("FAIL reset_data got %0d want 0", data_r); end
   endtask

   task automatic test_half_fill();
      for (int i = 1; i <= 8; i++) write_byte(8'(i));
      n_checks++; if (level !== 8'd64) begin n_fail++; $display("FAIL half_level got %0d want 64", level); end
      n_checks++; if (half_full !== 1'b1) begin n_fail++; $display("FAIL half_flag got %b want 1", half_full); end
      n_checks++; if (empty !== 1'b0) begin n_fail++; $display("FAIL half_empty got %b want 0", empty); end
      n_checks++; if (full !== 1'b0) begin n_fail++; $display("FAIL half_full_flag got %b want 0", full); end
      n_checks++; if (data_r !== 3'd1) begin n_fail++; $display("FAIL half_data got %0d want 1", data_r); end
   endtask

   task automatic test_fill_overflow();
      for (int i = 9; i <= 16; i++) write_byte(8'(i));
      n_checks++; if (level !== 8'd128) begin n_fail++; $display("FAIL fill_level got %0d want 128", level); end
      n_checks++; if (full !== 1'b1) begin n_fail++; $display("FAIL fill_full got %b want 1", full); end
      n_checks++; if (half_full !== 1'b0) begin n_fail++; $display("FAIL fill_half got %b want 0", half_full); end
      write_byte(8'h63);
      n_checks++; if (overflow !== 1'b1) begin n_fail++; $display("FAIL ovf_set got %b want 1", overflow); end
      n_checks++; if (level !== 8'd128) begin n_fail++; $display("FAIL ovf_level got %0d want 128", level); end
      err_clr = 1'b1; write_byte(8'h77); err_clr = 1'b0;
      n_checks++; if (overflow !== 1'b1) begin n_fail++; $display("FAIL ovf_set_wins got %b want 1", overflow); end
      err_clr = 1'b1; tick(); err_clr = 1'b0;
      n_checks++; if (overflow !== 1'b0) begin n_fail++; $display("FAIL ovf_clear got %b want 0", overflow); end
      n_checks++; if (data_r !== 3'd1) begin n_fail++; $display("FAIL ovf_data got %0d want 1", data_r); end
   endtask

   task automatic test_read_order();
      logic [2:0] exp_seq [6] = '{3'd1, 3'd0, 3'd0, 3'd1, 3'd0, 3'd6};
      r_en = 1'b1;
      for (int i = 0; i < 6; i++) begin
         n_checks++;
         if (data_r !== exp_seq[i]) begin
            n_fail++; $display("FAIL read_seq[%0d] got %0d want %0d", i, data_r, exp_seq[i]);
         end
         tick();
      end
      r_en = 1'b0;
      n_checks++; if (level !== 8'd110) begin n_fail++; $display("FAIL read_level got %0d want 110", level); end
      n_checks++; if (full !== 1'b0) begin n_fail++; $display("FAIL read_full got %b want 0", full); end
      write_byte(8'h01); write_byte(8'h02);
      n_checks++; if (level !== 8'd126) begin n_fail++; $display("FAIL l126_level got %0d want 126", level); end
      n_checks++; if (full !== 1'b1) begin n_fail++; $display("FAIL l126_full got %b want 1", full); end
      r_en = 1'b1; tick(); tick(); r_en = 1'b0;
      n_checks++; if (level !== 8'd120) begin n_fail++; $display("FAIL l120_level got %0d want 120", level); end
      n_checks++; if (full !== 1'b0) begin n_fail++; $display("FAIL l120_full got %b want 0", full); end
      n_checks++; if (data_r !== 3'd4) begin n_fail++; $display("FAIL l120_data got %0d want 4", data_r); end
      write_byte(8'h03);
      n_checks++; if (level !== 8'd128) begin n_fail++; $display("FAIL wrap_level got %0d want 128", level); end
      n_checks++; if (full !== 1'b1) begin n_fail++; $display("FAIL wrap_full got %b want 1", full); end
   endtask

   task automatic test_simultaneous();
      logic [2:0] exp_seq [6] = '{3'd4, 3'd0, 3'd4, 3'd2, 3'd0, 3'd4};
      r_en = 1'b1;
      for (int i = 0; i < 6; i++) begin
         n_checks++;
         if (data_r !== exp_seq[i]) begin
            n_fail++; $display("FAIL drain_seq[%0d] got %0d want %0d", i, data_r, exp_seq[i]);
         end
         tick();
      end
      r_en = 1'b0;
      n_checks++; if (level !== 8'd110) begin n_fail++; $display("FAIL pre_sim_level got %0d want 110", level); end
      n_checks++; if (data_r !== 3'd1) begin n_fail++; $display("FAIL pre_sim_data got %0d want 1", data_r); end
      w_en = 1'b1; r_en = 1'b1; data_w = 8'hAA; tick(); w_en = 1'b0; r_en = 1'b0;
      n_checks++; if (level !== 8'd115) begin n_fail++; $display("FAIL sim_level got %0d want 115", level); end
      n_checks++; if (data_r !== 3'd0) begin n_fail++; $display("FAIL sim_data got %0d want 0", data_r); end
   endtask

   task automatic test_wrap_read();
      r_en = 1'b1;
      for (int i = 0; i < 27; i++) tick();
      r_en = 1'b0;
      n_checks++; if (level !== 8'd34) begin n_fail++; $display("FAIL wrap_rd_level got %0d want 34", level); end
      n_checks++; if (data_r !== 3'd4) begin n_fail++; $display("FAIL wrap_rd_data got %0d want 4", data_r); end
      r_en = 1'b1; tick(); r_en = 1'b0;
      n_checks++; if (level !== 8'd31) begin n_fail++; $display("FAIL post_wrap_level got %0d want 31", level); end
      n_checks++; if (data_r !== 3'd0) begin n_fail++; $display("FAIL post_wrap_data got %0d want 0", data_r); end
   endtask

   task automatic test_underflow_tail();
      rst = 1'b1; tick(); rst = 1'b0;
      write_byte(8'h05);
      n_checks++; if (level !== 8'd8) begin n_fail++; $display("FAIL unf_fill_level got %0d want 8", level); end
      n_checks++; if (data_r !== 3'd5) begin n_fail++; $display("FAIL unf_rd0 got %0d want 5", data_r); end
      r_en = 1'b1; tick();
      n_checks++; if (data_r !== 3'd0) begin n_fail++; $display("FAIL unf_rd1 got %0d want 0", data_r); end
      tick(); r_en = 1'b0;
      n_checks++; if (level !== 8'd2) begin n_fail++; $display("FAIL tail_level got %0d want 2", level); end
      n_checks++; if (empty !== 1'b1) begin n_fail++; $display("FAIL tail_empty got %b want 1", empty); end
      n_checks++; if (data_r !== 3'd0) begin n_fail++; $display("FAIL tail_data got %0d want 0", data_r); end
      r_en = 1'b1; tick(); r_en = 1'b0;
      n_checks++; if (underflow !== 1'b1) begin n_fail++; $display("FAIL unf_set got %b want 1", underflow); end
      n_checks++; if (level !== 8'd2) begin n_fail++; $display("FAIL unf_level got %0d want 2", level); end
      err_clr = 1'b1; tick(); err_clr = 1'b0;
      n_checks++; if (underflow !== 1'b0) begin n_fail++; $display("FAIL unf_clear got %b want 0", underflow); end
      r_en = 1'b1; err_clr = 1'b1; tick(); r_en = 1'b0; err_clr = 1'b0;
      n_checks++; if (underflow !== 1'b1) begin n_fail++; $display("FAIL unf_set_wins got %b want 1", underflow); end
   endtask

   task automatic test_reset_mid_burst();
      w_en = 1'b1; data_w = 8'hFF;
      tick(); tick(); tick();
      rst = 1'b1; tick(); rst = 1'b0; w_en = 1'b0;
      n_checks++; if (level !== 8'd0) begin n_fail++; $display("FAIL mid_rst_level got %0d want 0", level); end
      n_checks++; if (data_r !== 3'd0) begin n_fail++; $display("FAIL mid_rst_data got %0d want 0", data_r); end
      n_checks++; if (empty !== 1'b1) begin n_fail++; $display("FAIL mid_rst_empty got %b want 1", empty); end
      n_checks++; if (underflow !== 1'b0) begin n_fail++; $display("FAIL mid_rst_unf got %b want 0", underflow); end
      n_checks++; if (half_full !== 1'b0) begin n_fail++; $display("FAIL mid_rst_half got %b want 0", half_full); end
      // Stale 1s sit in storage right after the tail; they must stay masked
      write_byte(8'hFF);
      r_en = 1'b1; tick(); tick(); r_en = 1'b0;
      n_checks++; if (level !== 8'd2) begin n_fail++; $display("FAIL mask_level got %0d want 2", level); end
      n_checks++; if (data_r !== 3'd3) begin n_fail++; $display("FAIL mask_data got %0d want 3", data_r); end
   endtask

   initial begin
      #1;
      test_reset();
      test_half_fill();
      test_fill_overflow();
      test_read_order();
      test_simultaneous();
      test_wrap_read();
      test_underflow_tail();
      test_reset_mid_burst();
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog expired after %0d checks", n_checks);
      $fatal(1);
   end

endmodule

// File: doc/bitstream_fifo_conv.md
Name: bitstream_fifo_conv

Overview:
Parametrised width-converting FIFO. It accepts WIN-bit writes and returns WOUT-bit reads from a single circular bit buffer. The bit order is LSB-first: bit 0 of the first word written is the first bit read. It extends the fixed 8-to-3 converter FIFO to arbitrary widths and capacity, and adds simultaneous read/write, an exact fill level, and sticky overflow/underflow flags that software can clear. It sits between byte-oriented producers and narrow-symbol consumers, such as encoders and serialisers.

Parameters:
WIN, 8, write word width in bits (>=1)
WOUT, 3, read chunk width in bits (>=1)
CAP, 128, buffer capacity in bits (>= 2*max(WIN,WOUT); need not be a power of two)
LW, $clog2(CAP+1), width of the level output (derived; do not override)

Ports:
clk  in  1  clock; all state updates on the rising edge
rst  in  1  synchronous reset, active-high
w_en  in  1  write request
data_w  in  WIN  write word
r_en  in  1  read request (pop WOUT bits)
err_clr  in  1  clears the sticky overflow and underflow flags
data_r  out  WOUT  head chunk, first-word-fall-through
empty  out  1  level < WOUT
full  out  1  CAP - level < WIN
half_full  out  1  level >= CAP/2 and not full
overflow  out  1  sticky: a write was attempted while full
underflow  out  1  sticky: a read was attempted while empty
level  out  LW  number of valid bits stored

Behaviour:
- Storage: CAP-bit array with bit-granular write pointer wp and read pointer rp, each in 0..CAP-1, incremented modulo CAP.
  - A word or chunk may straddle the wrap point; bits are stored and read in sequence across the wrap.
- Reset (rst=1 at an edge, including mid-operation):
  - wp=rp=0, level=0, overflow=0, underflow=0.
  - Outputs after reset: empty=1, full=0, half_full=0, data_r=0.
  - Array contents are not cleared and must not be observable.
- Write accept: wr = w_en & ~full.
  - On accept, data_w[i] is stored at bit (wp+i) mod CAP, and wp advances by WIN.
- Read accept: rd = r_en & ~empty, then rp advances by WOUT.
- Acceptance decisions use the pre-edge flags.
- Simultaneous accepted read and write in one cycle: level_next = level + WIN*wr - WOUT*rd, with no bypass.
  - A write to a full FIFO is rejected even if a read is accepted in the same cycle.
- data_r is combinational: data_r[i] = bit (rp+i) mod CAP when i < level, else 0.
  - This makes data_r = 0 at reset, and gives a zero-padded partial tail when 0 < level < WOUT.
  - The head chunk is valid before r_en is asserted; the next chunk appears in the cycle after an accepted read.
- Flags are combinational from level (empty, full, half_full).
- Error flags are registered and sticky:
  - overflow sets on the edge where w_en & full.
  - underflow sets on the edge where r_en & empty.
  - Both clear on the edge where err_clr=1.
  - If a set condition and err_clr occur in the same cycle, set wins.
- A rejected access changes no pointer, level, or data.
- Full is space-based, not count-based. The FIFO reports full whenever fewer than WIN bits are free; for example, 126/128 bits is full when WIN=8.

Test Plan:
(All scenarios use the default parameters: WIN=8, WOUT=3, CAP=128.)
1. Reset: hold rst for 2 cycles -> empty=1, full=0, half_full=0, overflow=0, underflow=0, level=0, data_r=0.
2. Half fill: write 0x01..0x08 -> level=64, half_full=1, empty=0, full=0, data_r=1.
3. Fill and overflow: write 0x09..0x10 -> level=128, full=1, half_full=0. Then write 0x63 -> overflow=1, level stays 128. Assert err_clr together with a second write to the still-full FIFO -> overflow stays 1.
4. Read order: six consecutive reads (r_en held) -> data_r sequence 1,0,0,1,0,6, then level=110, full=0. Write 0x01,0x02 -> level=126, full=1. Two reads -> level=120, full=0. Write 0x03 -> level=128, full=1, exercising the wrap.
5. Simultaneous access at level=110: assert w_en and r_en together for one cycle -> level=115, both accesses accepted, data_r advances by one chunk.
6. Underflow and partial tail:
   - From reset, write 0x05 (level 8), then read twice, collecting data_r values 5 then 0 -> level=2, empty=1, data_r=0.
   - Assert r_en -> underflow=1, level stays 2.
   - Assert err_clr -> underflow=0.
   - Assert rst during a w_en burst -> all outputs return to their reset values at the next edge.
